// File: rtl/ms_timer_scheduler_if.sv
// rtl/ms_timer_scheduler_if.sv - request/status bundle between ms timer clients and the scheduler
interface ms_timer_scheduler_if #(
    parameter int NUM_CH = 4,
    parameter int CW     = 16
);
    logic [NUM_CH-1:0]    req_valid;
    logic [NUM_CH*CW-1:0] req_ms;
    logic [NUM_CH-1:0]    cancel;
    logic [NUM_CH-1:0]    req_ready;
    logic [NUM_CH-1:0]    busy;
    logic [NUM_CH-1:0]    expire;
    logic                 tick_ms;

    modport master (
        output req_valid, req_ms, cancel,
        input  req_ready, busy, expire, tick_ms
    );

    modport slave (
        input  req_valid, req_ms, cancel,
        output req_ready, busy, expire, tick_ms
    );
endinterface

// File: rtl/ms_timer_scheduler.sv
// rtl/ms_timer_scheduler.sv - shared 1 ms prescaler with round-robin armed countdown channels
module ms_timer_scheduler #(
    parameter int CLK_PER_MS = 100000,
    parameter int NUM_CH     = 4,
    parameter int CW         = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    ms_timer_scheduler_if.slave   bus
);
    localparam int PSW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int PTW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [PSW-1:0] PS_LAST = PSW'(CLK_PER_MS - 1);

    logic [PSW-1:0]    presc_q, presc_d;
    logic              tick_q, tick_d;
    logic [PTW-1:0]    ptr_q, ptr_d;
    logic [NUM_CH-1:0] busy_q, busy_d;
    logic [NUM_CH-1:0] expire_q, expire_d;
    logic [NUM_CH-1:0] elig, grant;
    logic [CW-1:0]     cnt_q [NUM_CH];
    logic [CW-1:0]     cnt_d [NUM_CH];

    always_comb begin
        tick_d  = (presc_q == PS_LAST);
        presc_d = tick_d ? '0 : presc_q + 1'b1;
    end

    // Round-robin search starting at ptr; first eligible channel wins the load path.
    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        ptr_d = ptr_q;
        elig  = bus.req_valid & ~busy_q & ~bus.cancel;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(ptr_q) + k) % NUM_CH;
            if (grant == '0 && elig[idx]) begin
                grant[idx] = 1'b1;
                ptr_d      = PTW'((idx + 1) % NUM_CH);
            end
        end
    end

    // Grant implies idle, so a load never collides with cancel or countdown.
    always_comb begin
        busy_d   = busy_q;
        expire_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                if (bus.req_ms[i*CW +: CW] != '0) begin
                    cnt_d[i]  = bus.req_ms[i*CW +: CW];
                    busy_d[i] = 1'b1;
                end else begin
                    expire_d[i] = 1'b1;
                end
            end else if (busy_q[i] && bus.cancel[i]) begin
                cnt_d[i]  = '0;
                busy_d[i] = 1'b0;
            end else if (busy_q[i] && tick_q) begin
                if (cnt_q[i] == CW'(1)) begin
                    cnt_d[i]    = '0;
                    busy_d[i]   = 1'b0;
                    expire_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q  <= '0;
            tick_q   <= 1'b0;
            ptr_q    <= '0;
            busy_q   <= '0;
            expire_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            presc_q  <= presc_d;
            tick_q   <= tick_d;
            ptr_q    <= ptr_d;
            busy_q   <= busy_d;
            expire_q <= expire_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.req_ready = grant;
    assign bus.busy      = busy_q;
    assign bus.expire    = expire_q;
    assign bus.tick_ms   = tick_q;
endmodule

// File: tb/tb_ms_timer_scheduler.sv
// tb/tb_ms_timer_scheduler.sv - directed bench for ms_timer_scheduler
module tb_ms_timer_scheduler;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_miss;
    int   e_n, e_tick, b_n, t_n;

    ms_timer_scheduler_if #(.NUM_CH(4), .CW(16)) bus ();

    ms_timer_scheduler #(
        .CLK_PER_MS(10),
        .NUM_CH    (4),
        .CW        (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input int bound);
        for (int i = 0; i < bound; i++) begin
            step();
            if (bus.tick_ms) break;
        end
        chk("tick_wait", 32'(bus.tick_ms), 32'd1);
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (bus.busy == 4'd0) break;
            step();
        end
        chk("idle_wait", 32'(bus.busy), 32'd0);
    endtask

    task automatic arm(input int ch, input logic [15:0] ms, input logic [3:0] exp_ready);
        bus.req_valid[ch]        = 1'b1;
        bus.req_ms[ch*16 +: 16] = ms;
        #1;
        chk("arm_ready", 32'(bus.req_ready), 32'(exp_ready));
        step();
        bus.req_valid[ch] = 1'b0;
    endtask

    // Steps n edges; reports expire pulses, ticks seen before the first expire,
    // busy samples before the first expire, and total ticks in the window.
    task automatic watch(input int ch, input int n, output int exp_n, output int exp_tick,
                         output int busy_n, output int tick_n);
        exp_n = 0; exp_tick = -1; busy_n = 0; tick_n = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (bus.expire[ch]) begin
                if (exp_n == 0) exp_tick = tick_n;
                exp_n++;
            end
            if (exp_n == 0 && bus.busy[ch]) busy_n++;
            if (bus.tick_ms) tick_n++;
        end
    endtask

    initial begin
        n_vec = 0;
        n_miss = 0;
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_ms    = '0;
        bus.cancel    = '0;

        // reset state and prescaler cadence
        step();
        step();
        chk("rst_busy",   32'(bus.busy),      32'd0);
        chk("rst_expire", 32'(bus.expire),    32'd0);
        chk("rst_tick",   32'(bus.tick_ms),   32'd0);
        chk("rst_ready",  32'(bus.req_ready), 32'd0);
        rst = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            step();
            chk("tick_cadence", 32'(bus.tick_ms), (k % 10 == 0) ? 32'd1 : 32'd0);
        end

        // all four request at once from ptr 0
        bus.req_valid = 4'b1111;
        bus.req_ms    = {4{16'd2}};
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rr_grant", 32'(bus.req_ready), 32'd1 << k);
            step();
            bus.req_valid[k] = 1'b0;
            #1;
        end
        chk("rr_none_left", 32'(bus.req_ready), 32'd0);
        chk("rr_all_busy",  32'(bus.busy),      32'hF);
        wait_idle(100);
        bus.req_valid = 4'b1001;
        bus.req_ms    = {16'd1, 16'd0, 16'd0, 16'd1};
        #1;
        chk("ptr_wrapped", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid[0] = 1'b0;
        #1;
        chk("ptr_next", 32'(bus.req_ready), 32'h8);
        step();
        bus.req_valid[3] = 1'b0;
        wait_idle(100);

        // ch0 arms 3 ms away from a tick
        wait_tick(20);
        step();
        arm(0, 16'd3, 4'b0001);
        chk("arm3_busy", 32'(bus.busy[0]), 32'd1);
        watch(0, 35, e_n, e_tick, b_n, t_n);
        chk("arm3_exp_n",    32'(e_n),    32'd1);
        chk("arm3_exp_tick", 32'(e_tick), 32'd3);
        chk("arm3_busy_n",   32'(b_n),    32'd28);
        chk("arm3_idle",     32'(bus.busy[0]), 32'd0);

        // ch1 5 ms, cancelled after the 2nd tick
        wait_tick(20);
        step();
        arm(1, 16'd5, 4'b0010);
        wait_tick(20);
        wait_tick(20);
        bus.cancel[1] = 1'b1;
        step();
        chk("cancel_busy",   32'(bus.busy[1]),   32'd0);
        chk("cancel_expire", 32'(bus.expire[1]), 32'd0);
        bus.cancel[1] = 1'b0;
        watch(1, 100, e_n, e_tick, b_n, t_n);
        chk("cancel_no_exp", 32'(e_n), 32'd0);

        // cancel blocks eligibility; zero duration expires immediately
        bus.req_valid[2]     = 1'b1;
        bus.cancel[2]        = 1'b1;
        bus.req_ms[32 +: 16] = 16'd0;
        #1;
        chk("cancel_idle_ready", 32'(bus.req_ready), 32'd0);
        bus.cancel[2] = 1'b0;
        #1;
        chk("zero_ready", 32'(bus.req_ready), 32'h4);
        step();
        bus.req_valid[2] = 1'b0;
        chk("zero_expire", 32'(bus.expire[2]), 32'd1);
        chk("zero_busy",   32'(bus.busy[2]),   32'd0);
        step();
        chk("zero_pulse_end", 32'(bus.expire[2]), 32'd0);

        // load coincides with tick: load wins
        wait_tick(20);
        arm(3, 16'd3, 4'b1000);
        watch(3, 35, e_n, e_tick, b_n, t_n);
        chk("tickarm_exp_n",    32'(e_n),    32'd1);
        chk("tickarm_exp_tick", 32'(e_tick), 32'd3);

        // full-range count
        arm(0, 16'hFFFF, 4'b0001);
        watch(0, 1000, e_n, e_tick, b_n, t_n);
        chk("max_ticks", 32'(t_n),         32'd100);
        chk("max_busy",  32'(bus.busy[0]), 32'd1);
        chk("max_no_exp", 32'(e_n),        32'd0);
        bus.cancel[0] = 1'b1;
        step();
        chk("max_cancel", 32'(bus.busy[0]), 32'd0);
        bus.cancel[0] = 1'b0;

        // async reset mid-countdown
        arm(2, 16'd4, 4'b0100);
        wait_tick(20);
        wait_tick(20);
        chk("pre_rst_busy", 32'(bus.busy[2]), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("async_busy",   32'(bus.busy),    32'd0);
        chk("async_expire", 32'(bus.expire),  32'd0);
        chk("async_tick",   32'(bus.tick_ms), 32'd0);
        step();
        step();
        rst = 1'b0;
        watch(2, 60, e_n, e_tick, b_n, t_n);
        chk("post_rst_no_exp", 32'(e_n), 32'd0);
        chk("post_rst_busy_n", 32'(b_n), 32'd0);
        chk("post_rst_ticks",  32'(t_n), 32'd6);
        arm(2, 16'd1, 4'b0100);
        chk("rearm_busy", 32'(bus.busy[2]), 32'd1);
        watch(2, 25, e_n, e_tick, b_n, t_n);
        chk("rearm_exp_n",    32'(e_n),    32'd1);
        chk("rearm_exp_tick", 32'(e_tick), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
